// File: rtl/mips_mem_responder.sv
// mips_mem_responder: single-port word RAM servicing a MIPS core's fetch and data phases
// Optional feature macro: MEM_FAULT_CHECK_EN (access fault detection and suppression).
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   pc                          - instruction byte address from the core
//   instruction                 - registered instruction word
//   data_address, write_data    - data byte address and store data from the core
//   mem_read, mem_write         - load/store requests, decoded from instruction
//   data                        - registered load data
//   hold                        - stall; low for exactly one commit cycle per instruction
//   load_we, load_addr, load_data - program-load port, honoured only in reset
//   ret_count                   - committed instruction count
//   fault                       - sticky access fault (0 unless MEM_FAULT_CHECK_EN)
module mips_mem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic [31:0]       instruction,
    input  logic [31:0]       data_address,
    input  logic [31:0]       write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [31:0]       data,
    output logic              hold,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [31:0]       ret_count,
    output logic              fault
);
`ifdef MEM_FAULT_CHECK_EN
    localparam bit FLT_EN = 1'b1;
`else
    localparam bit FLT_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IFETCH, EXEC, DREAD} state_t;
    state_t state_q, state_d;
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] instruction_q, instruction_d, data_q, data_d, ret_count_q, ret_count_d, wr_data;
    logic fault_q, fault_d, acc_bad, we, in_exec, do_load;
    logic [ADDR_W-1:0] pc_idx, d_idx, wr_addr;
    logic unused_bits;
    assign unused_bits = ^{pc[31:ADDR_W+2], pc[1:0]};
    always_comb begin
        pc_idx = pc[ADDR_W+1:2];
        d_idx = data_address[ADDR_W+1:2];
        in_exec = state_q == EXEC;
        // A simultaneous read and write is a store, and under fault checking it is also a fault.
        acc_bad = FLT_EN && in_exec && (((mem_read || mem_write) &&
                  (data_address[1:0] != 2'b0 || data_address[31:ADDR_W+2] != '0)) ||
                  (mem_read && mem_write));
        do_load = in_exec && mem_read && !mem_write;
        // Reset forces a stall so no commit is counted and the core stays frozen.
        hold = reset || state_q == IFETCH || do_load;
        // The load port owns the RAM write path only while reset is high, so the two never collide.
        we = reset ? load_we : in_exec && mem_write && !acc_bad;
        wr_addr = reset ? load_addr : d_idx;
        wr_data = reset ? load_data : write_data;
        state_d = reset ? IFETCH : state_q == IFETCH ? EXEC : do_load ? DREAD : IFETCH;
        instruction_d = reset ? '0 : state_q == IFETCH ? mem[pc_idx] : instruction_q;
        data_d = reset ? '0 : do_load ? (acc_bad ? '0 : mem[d_idx]) : data_q;
        ret_count_d = reset ? '0 : ret_count_q + {31'b0, !hold};
        fault_d = !reset && (fault_q || acc_bad);
    end
    always_ff @(posedge clk) begin
        state_q <= state_d;
        instruction_q <= instruction_d;
        data_q <= data_d;
        ret_count_q <= ret_count_d;
        fault_q <= fault_d;
        if (we) mem[wr_addr] <= wr_data;
    end
    assign instruction = instruction_q;
    assign data = data_q;
    assign ret_count = ret_count_q;
    assign fault = fault_q;
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: self-checking bench acting as the processor around mips_mem_responder
module tb_mips_mem_responder;
`ifdef MEM_FAULT_CHECK_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif
    localparam int AW = 10;
    logic clk = 1'b0, reset = 1'b1, load_we = 1'b0;
    logic [31:0] pc = '0, write_data = '0, load_data = '0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0] instruction, data, ret_count, data_address;
    logic hold, fault, mem_read, mem_write;
    logic [5:0] op;
    int total = 0, bad = 0;
    logic [31:0] exp_ret, exp_dat;
    logic [31:0] prog [0:63];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] wd;
        int          len;
        logic [31:0] dat;
        logic        flt;
    } vec_t;
    vec_t tv [0:10];

    always #5 clk = ~clk;

    // Processor decode: lw=0x23, sw=0x2B, 0x3F asserts both; address = zero-extended imm.
    assign op = instruction[31:26];
    assign mem_read = op == 6'h23 || op == 6'h3F;
    assign mem_write = op == 6'h2B || op == 6'h3F;
    assign data_address = {16'h0, instruction[15:0]};

    mips_mem_responder #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
        .data_address(data_address), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .data(data), .hold(hold),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .ret_count(ret_count), .fault(fault)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        pc = '0;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            load_we = 1'b1;
            load_addr = AW'(i);
            load_data = prog[i];
            @(posedge clk); #1;
        end
        load_we = 1'b0;
        @(negedge clk);
        chk("rst_hold", hold, 1);
        chk("rst_instr", instruction, 0);
        chk("rst_data", data, 0);
        chk("rst_ret", ret_count, 0);
        chk("rst_fault", fault, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ret = 0;
        exp_dat = 0;
    endtask

    task automatic do_instr(input logic [31:0] ei, input logic [31:0] wd, input int len,
                            input logic [31:0] ed, input logic ef);
        write_data = wd;
        @(negedge clk);
        chk("hold_fetch", hold, 1);
        @(posedge clk); @(negedge clk);
        chk("instr", instruction, ei);
        chk("hold_exec", hold, {31'b0, len == 3});
        if (len == 3) begin
            @(posedge clk); @(negedge clk);
            exp_dat = ed;
            chk("load_data", data, exp_dat);
            chk("hold_dread", hold, 0);
        end else chk("data_keep", data, exp_dat);
        @(posedge clk); #1;
        exp_ret++;
        chk("ret_count", ret_count, exp_ret);
        chk("fault", fault, {31'b0, ef});
    endtask

    initial begin
        // Three back-to-back ALU instructions: hold low on cycles 2, 4, 6.
        for (int i = 0; i < 3; i++) prog[i] = 32'h00000020;
        do_reset(3);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("hold_seq", hold, c % 2);
            @(posedge clk); #1;
            if (c % 2 == 0) pc += 4;
        end
        chk("ret_three", ret_count, 3);

        // Directed program table.
        tv[0]  = '{32'h20010005, 32'h0,        2, 32'h0, 1'b0};
        tv[1]  = '{32'hAC000040, 32'hDEADBEEF, 2, 32'h0, 1'b0};
        tv[2]  = '{32'h8C000040, 32'h0,        3, 32'hDEADBEEF, 1'b0};
        tv[3]  = '{32'h00000020, 32'h0,        2, 32'h0, 1'b0};
        tv[4]  = '{32'h00221820, 32'h0,        2, 32'h0, 1'b0};
        tv[5]  = '{32'h00000000, 32'h0,        2, 32'h0, 1'b0};
        tv[6]  = '{32'h8C001000, 32'h0,        3, FE ? 32'h0 : 32'h20010005, FE};
        tv[7]  = '{32'hAC000042, 32'h12345678, 2, 32'h0, FE};
        tv[8]  = '{32'h8C000040, 32'h0,        3, FE ? 32'hDEADBEEF : 32'h12345678, FE};
        tv[9]  = '{32'hFC000040, 32'hCAFEF00D, 2, 32'h0, FE};
        tv[10] = '{32'h8C000040, 32'h0,        3, FE ? 32'hDEADBEEF : 32'hCAFEF00D, FE};
        for (int i = 0; i < 11; i++) prog[i] = tv[i].instr;
        do_reset(11);
        for (int i = 0; i < 11; i++) begin
            do_instr(tv[i].instr, tv[i].wd, tv[i].len, tv[i].dat, tv[i].flt);
            pc += 4;
        end

        // Reset during a store's EXEC cycle aborts the write; then reset during DREAD.
        for (int i = 0; i < 33; i++) prog[i] = 32'h0;
        prog[0] = 32'hAC000080;
        prog[1] = 32'h8C000080;
        prog[32] = 32'h11112222;
        do_reset(33);
        write_data = 32'h55555555;
        @(posedge clk); @(negedge clk);
        chk("abort_st_hold", hold, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_st_hold1", hold, 1);
        chk("abort_st_ret", ret_count, 0);
        reset = 1'b0;
        exp_ret = 0;
        exp_dat = 0;
        pc = 4;
        do_instr(32'h8C000080, 32'h0, 3, 32'h11112222, 1'b0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("dread_data", data, 32'h11112222);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_ld_hold", hold, 1);
        chk("abort_ld_ret", ret_count, 0);

        // Randomized closed-loop run against a reference model of the RAM and the rules.
        for (int i = 0; i < 64; i++) begin
            int k;
            logic [15:0] imm;
            k = $urandom_range(0, 3);
            imm = 16'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 7) == 0) imm += 16'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) imm += 16'h1000;
            prog[i] = k == 0 ? {6'h23, 10'($urandom), imm} : k == 1 ? {6'h2B, 10'($urandom), imm} :
                      k == 2 ? {6'h08, 10'($urandom), imm} : ($urandom_range(0, 3) == 0 ? {6'h3F, 10'h0, imm} : {6'h00, 26'($urandom)});
            ref_mem[i] = prog[i];
        end
        do_reset(64);
        begin
            logic ef;
            ef = 1'b0;
            for (int n = 0; n < 300; n++) begin
                logic [31:0] iw, a, wd, ed;
                logic rd, wr, fl;
                int di;
                pc = ($urandom_range(0, 63) << 2) | ($urandom_range(0, 1) == 1 ? 32'h1000 : 32'h0) | $urandom_range(0, 3);
                iw = ref_mem[(pc >> 2) % (1 << AW)];
                a = {16'h0, iw[15:0]};
                rd = iw[31:26] == 6'h23 || iw[31:26] == 6'h3F;
                wr = iw[31:26] == 6'h2B || iw[31:26] == 6'h3F;
                fl = FE && (((rd || wr) && (a % 4 != 0 || a >= (4 << AW))) || (rd && wr));
                di = (a >> 2) % (1 << AW);
                wd = $urandom;
                ed = fl ? 32'h0 : ref_mem[di];
                ef = ef || fl;
                do_instr(iw, wd, (rd && !wr) ? 3 : 2, ed, ef);
                if (wr && !fl) ref_mem[di] = wd;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for `mod_mips_processor`: owns a single-port word RAM and services both the processor's instruction fetch (address `pc`) and its data access (`data_address`, `mem_read` / `mem_write`). Because one RAM port cannot serve both in one cycle, the block sequences fetch and data phases with a small FSM. It stalls the processor through `hold`, releasing it for exactly one commit cycle per instruction. It also provides a reset-time program-load port and a retired-instruction counter.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width; RAM depth is 2^ADDR_W words of 32 bits.

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pc` in 32: instruction byte address from the processor.
- `instruction` out 32: registered instruction word to the processor.
- `data_address` in 32: data byte address from the processor.
- `write_data` in 32: store data from the processor.
- `mem_read` in 1: processor load request, combinational from `instruction`.
- `mem_write` in 1: processor store request, combinational from `instruction`.
- `data` out 32: registered load data to the processor.
- `hold` out 1: 1 = processor must not update PC or register file.
- `load_we` in 1: program-load write strobe, honoured only while `reset` = 1.
- `load_addr` in ADDR_W: program-load word address.
- `load_data` in 32: program-load word.
- `ret_count` out 32: count of committed instructions.
- `fault` out 1: sticky access fault (see Configuration).

## Operation
- Word index = byte address [ADDR_W+1:2]; upper bits ignored (wrap), bits [1:0] ignored.
- FSM states: `IFETCH`, `EXEC`, `DREAD`.
- `IFETCH`: RAM reads mem[pc index]. `instruction` is registered at the edge. `hold` = 1. Next state is `EXEC`.
- `EXEC`: `instruction` is stable, so the processor's `mem_read`, `mem_write` and `data_address` are valid.
  - Neither asserted: `hold` = 0 (commit). Next state is `IFETCH`.
  - `mem_write` = 1: mem[data index] <= `write_data` at this edge. `hold` = 0 (commit). Next state is `IFETCH`.
  - `mem_read` = 1, `mem_write` = 0: RAM reads data index and `data` is registered. `hold` = 1. Next state is `DREAD`.
  - Both asserted: treated as a store; no read is performed.
- `DREAD`: `data` is valid. `hold` = 0 (commit). Next state is `IFETCH`.
- `ret_count` increments by 1 on every edge where `hold` = 0 and `reset` = 0. It wraps from 0xFFFFFFFF to 0.
- `data` holds its last value outside loads.
- Reset state: `instruction` = 0, `data` = 0, `hold` = 1, FSM = `IFETCH`, `ret_count` = 0, `fault` = 0.
- RAM contents are not cleared by reset.
- While `reset` = 1 and `load_we` = 1: mem[`load_addr`] <= `load_data`. `load_we` is ignored when `reset` = 0.

## Timing
- Latency from fetch start to commit: 2 cycles for ALU, branch and jump instructions; 2 for stores; 3 for loads.
- `hold` is low for exactly one cycle per instruction and never for two consecutive cycles.
- The processor's PC changes on the commit edge. The next `IFETCH` uses the new `pc`.
- `hold` is a registered function of state plus the combinational `mem_read`/`mem_write` in `EXEC`. This path must settle within one cycle.
- First fetch occurs in the first cycle after `reset` deasserts. That fetch reads address 0, since the processor PC is also reset to 0.
- Reset asserted mid-instruction (`EXEC` or `DREAD`): the access is aborted and no RAM write occurs at that edge. The state is reset and `ret_count` is cleared.
- RAM writes in `EXEC` and load-port writes are mutually exclusive, because the load port is active only in reset.

## Configuration
- `MEM_FAULT_CHECK_EN` defined:
  - In `EXEC` with `mem_read` or `mem_write` = 1, `data_address`[1:0] != 0 or `data_address`[31:ADDR_W+2] != 0 sets `fault` (sticky until reset).
  - A faulting store is suppressed (no RAM write), but the instruction still commits.
  - A faulting load returns `data` = 0.
  - Simultaneous `mem_read` and `mem_write` also sets `fault`.
- `MEM_FAULT_CHECK_EN` undefined: `fault` is tied to 0, addresses wrap silently, and no access is suppressed.

## Test plan
- Reset with load port writing word 0 = 0x20010005 (addi) → after release, `hold` pattern is 1,0; `ret_count` = 1 after the commit edge.
- Store 0xDEADBEEF at byte 0x40, then load from 0x40 → `hold` pattern is 1,0 (store) then 1,1,0 (load); `data` = 0xDEADBEEF in the `DREAD` cycle.
- Three back-to-back non-memory instructions → `hold` is low on cycles 2, 4 and 6 after reset release; `ret_count` = 3.
- Reset asserted in the `DREAD` cycle of a load → `hold` = 1 and `ret_count` = 0 next cycle; no RAM change.
- With `MEM_FAULT_CHECK_EN`: store to 0x42 → `fault` = 1, target word unchanged, `ret_count` still increments. Without the macro, `fault` stays 0.
- Address wrap: with `ADDR_W` = 10, load from 0x1000 returns the word at 0x0 (macro undefined).
